// File: rtl/iir_coeff_loader.sv
// rtl/iir_coeff_loader.sv - double-buffered coefficient loader for a two-SOS IIR filter
// Words fill a shadow bank in fixed order; the active bank is swapped in on an lr_clk falling edge.
module iir_coeff_loader (
    input  logic        state_clk,
    input  logic        reset,
    input  logic        lr_clk,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [17:0] wr_data,
    input  logic        wr_last,
    output logic [17:0] b11,
    output logic [17:0] b12,
    output logic [17:0] b13,
    output logic [17:0] a12,
    output logic [17:0] a13,
    output logic [17:0] b21,
    output logic [17:0] b22,
    output logic [17:0] b23,
    output logic [17:0] a22,
    output logic [17:0] a23,
    output logic [17:0] gain,
    output logic        swap_done,
    output logic        set_err,
    output logic [7:0]  commit_cnt
);

    typedef enum logic {
        LOAD,
        WAIT_FRAME
    } state_t;

    localparam int          NUM_WORDS = 11;
    localparam logic [3:0]  LAST_IDX  = 4'd10;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [17:0] shadow_q [NUM_WORDS];
    logic [17:0] active_q [NUM_WORDS];
    logic        lr_prev_q;
    logic        swap_done_q, swap_done_d;
    logic        set_err_q, set_err_d;
    logic [7:0]  commit_cnt_q, commit_cnt_d;
    logic        wr_fire;
    logic        lr_fall;
    logic        copy_en;

    assign wr_ready = (state_q == LOAD);
    assign wr_fire  = wr_valid && wr_ready;
    assign lr_fall  = lr_prev_q && !lr_clk;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        swap_done_d  = 1'b0;
        set_err_d    = set_err_q;
        commit_cnt_d = commit_cnt_q;
        copy_en      = 1'b0;
        case (state_q)
            LOAD: begin
                // A set is only complete when wr_last lands exactly on the gain word.
                if (wr_fire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = 4'd0;
                        if (wr_last) begin
                            state_d = WAIT_FRAME;
                        end else begin
                            set_err_d = 1'b1;
                        end
                    end else if (wr_last) begin
                        idx_d     = 4'd0;
                        set_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            WAIT_FRAME: begin
                if (lr_fall) begin
                    copy_en      = 1'b1;
                    swap_done_d  = 1'b1;
                    commit_cnt_d = commit_cnt_q + 8'd1;
                    state_d      = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge state_clk) begin
        if (reset) begin
            state_q      <= LOAD;
            idx_q        <= 4'd0;
            lr_prev_q    <= lr_clk;
            swap_done_q  <= 1'b0;
            set_err_q    <= 1'b0;
            commit_cnt_q <= 8'd0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= 18'h0;
                active_q[i] <= 18'h0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lr_prev_q    <= lr_clk;
            swap_done_q  <= swap_done_d;
            set_err_q    <= set_err_d;
            commit_cnt_q <= commit_cnt_d;
            if (wr_fire) begin
                shadow_q[idx_q] <= wr_data;
            end
            // Whole-bank copy in a single edge keeps the filter from seeing a mixed set.
            if (copy_en) begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign b11        = active_q[0];
    assign b12        = active_q[1];
    assign b13        = active_q[2];
    assign a12        = active_q[3];
    assign a13        = active_q[4];
    assign b21        = active_q[5];
    assign b22        = active_q[6];
    assign b23        = active_q[7];
    assign a22        = active_q[8];
    assign a23        = active_q[9];
    assign gain       = active_q[10];
    assign swap_done  = swap_done_q;
    assign set_err    = set_err_q;
    assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// tb/tb_iir_coeff_loader.sv - scoreboard bench for iir_coeff_loader
// Stimulus updates a set-level reference model and queues each expected commit; a monitor checks pulses.
module tb_iir_coeff_loader;

    typedef struct packed {
        logic [10:0][17:0] w;
        logic [7:0]        cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lr_clk = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [17:0] wr_data = 18'h0;
    logic        wr_last = 1'b0;
    logic [17:0] b11, b12, b13, a12, a13, b21, b22, b23, a22, a23, gain;
    logic        swap_done;
    logic        set_err;
    logic [7:0]  commit_cnt;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int exp_pulses = 0;

    exp_t              exp_q[$];
    logic [10:0][17:0] cur_active = '0;
    logic              rst_seen = 1'b0;

    logic [10:0][17:0] m_shadow;
    int                m_idx;
    logic              m_pending;
    logic              m_err;
    logic [7:0]        m_cnt;
    logic              m_lr_prev;

    wire [10:0][17:0] dut_act = {gain, a23, a22, b23, b22, b21, a13, a12, b13, b12, b11};

    iir_coeff_loader dut (
        .state_clk (clk),
        .reset     (reset),
        .lr_clk    (lr_clk),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .b11       (b11),
        .b12       (b12),
        .b13       (b13),
        .a12       (a12),
        .a13       (a13),
        .b21       (b21),
        .b22       (b22),
        .b23       (b23),
        .a22       (a22),
        .a23       (a23),
        .gain      (gain),
        .swap_done (swap_done),
        .set_err   (set_err),
        .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) rst_seen <= reset;

    // Monitor: every swap_done pulse consumes one expected commit; the bank is checked every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) cur_active = '0;
        if (swap_done === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL swap_unexpected actual=1 expected=0 cnt=%0d", commit_cnt);
            end else begin
                e = exp_q.pop_front();
                cur_active = e.w;
                chk("commit_cnt_at_swap", {24'h0, commit_cnt}, {24'h0, e.cnt});
            end
        end
        checks++;
        if (dut_act !== cur_active) begin
            failures++;
            $display("FAIL active_bank actual=%h expected=%h", dut_act, cur_active);
        end
    end

    task automatic model_clear();
        m_shadow  = '0;
        m_idx     = 0;
        m_pending = 1'b0;
        m_err     = 1'b0;
        m_cnt     = 8'd0;
        m_lr_prev = lr_clk;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("reset_wr_ready", {31'h0, wr_ready}, 32'h1);
        chk("reset_set_err", {31'h0, set_err}, 32'h0);
        chk("reset_commit_cnt", {24'h0, commit_cnt}, 32'h0);
    endtask

    // One clock cycle: drive inputs, apply the model's rules at the edge, check status after it.
    task automatic step(input logic v, input logic [17:0] d, input logic l, input logic lr);
        logic ready;
        logic fall;
        exp_t e;
        wr_valid = v;
        wr_data  = d;
        wr_last  = l;
        lr_clk   = lr;
        #1;
        ready = !m_pending;
        chk("wr_ready", {31'h0, wr_ready}, {31'h0, ready});
        @(posedge clk);
        fall = m_lr_prev && !lr;
        if (fall && m_pending) begin
            m_pending = 1'b0;
            m_cnt     = m_cnt + 8'd1;
            e.w       = m_shadow;
            e.cnt     = m_cnt;
            exp_q.push_back(e);
            exp_pulses++;
        end else if (v && ready) begin
            m_shadow[m_idx] = d;
            if (m_idx == 10 && l) begin
                m_pending = 1'b1;
                m_idx     = 0;
            end else if (m_idx == 10 || l) begin
                m_err = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        m_lr_prev = lr;
        #1;
        chk("set_err", {31'h0, set_err}, {31'h0, m_err});
        chk("commit_cnt", {24'h0, commit_cnt}, {24'h0, m_cnt});
    endtask

    task automatic load_set(input logic [17:0] base, input logic lr);
        for (int i = 0; i < 11; i++) step(1'b1, base + 18'(i), (i == 10), lr);
    endtask

    initial begin
        int lr_timer;
        logic lr_v;
        int p0;

        model_clear();
        do_reset();

        // Basic set, then 100 cycles of constant lr_clk with wr_valid held high.
        load_set(18'h10100, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b1, 18'($urandom), 1'b0, 1'b1);
        chk("hold_outputs_zero", {14'h0, b11}, 32'h0);
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("first_b11", {14'h0, b11}, 32'h10100);
        chk("first_gain", {14'h0, gain}, 32'h1010A);
        chk("first_cnt", {24'h0, commit_cnt}, 32'h1);
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("swap_pulse_one_cycle", {31'h0, swap_done}, 32'h0);

        // Early wr_last on the 5th word, then a good set.
        for (int i = 0; i < 5; i++) step(1'b1, 18'h2A000 + 18'(i), (i == 4), 1'b1);
        chk("early_last_err", {31'h0, set_err}, 32'h1);
        load_set(18'h03300, 1'b1);
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("after_err_b13", {14'h0, b13}, 32'h03302);

        // Eleven words without wr_last; the twelfth starts a new set at index 0.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 18'h05500 + 18'(i), 1'b0, 1'b1);
        chk("no_err_before_11th", {31'h0, set_err}, 32'h0);
        step(1'b1, 18'h0550A, 1'b0, 1'b1);
        chk("missing_last_err", {31'h0, set_err}, 32'h1);
        step(1'b1, 18'h3FFFF, 1'b0, 1'b1);
        for (int i = 1; i < 11; i++) step(1'b1, 18'h06600 + 18'(i), (i == 10), 1'b1);
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("twelfth_is_b11", {14'h0, b11}, 32'h3FFFF);

        // Falling edge on the final-word cycle must not commit.
        for (int i = 0; i < 10; i++) step(1'b1, 18'h07700 + 18'(i), 1'b0, 1'b1);
        step(1'b1, 18'h0770A, 1'b1, 1'b0);
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("same_cycle_no_commit", {14'h0, b11}, 32'h3FFFF);
        step(1'b0, 18'h0, 1'b0, 1'b1);
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("next_edge_commit", {14'h0, b11}, 32'h07700);

        // Reset in WAIT_FRAME discards the pending set.
        do_reset();
        load_set(18'h08800, 1'b1);
        do_reset();
        step(1'b0, 18'h0, 1'b0, 1'b0);
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("reset_wait_b11", {14'h0, b11}, 32'h0);
        chk("reset_wait_cnt", {24'h0, commit_cnt}, 32'h0);

        // Random traffic with independent lr_clk toggling and occasional malformed sets.
        lr_timer = 1;
        lr_v = lr_clk;
        for (int c = 0; c < 1500; c++) begin
            logic v;
            logic l;
            lr_timer--;
            if (lr_timer == 0) begin
                lr_v = ~lr_v;
                lr_timer = $urandom_range(1, 20);
            end
            v = ($urandom % 4) != 0;
            if (m_idx == 10) l = ($urandom % 8) != 0;
            else             l = ($urandom % 40) == 0;
            step(v, 18'($urandom), l, lr_v);
        end

        // 256 commits from reset: the counter wraps to zero.
        do_reset();
        p0 = pulses;
        for (int s = 0; s < 256; s++) begin
            load_set(18'($urandom), 1'b1);
            step(1'b0, 18'h0, 1'b0, 1'b0);
        end
        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("wrap_cnt", {24'h0, commit_cnt}, 32'h0);
        chk("wrap_pulses", pulses - p0, 256);

        step(1'b0, 18'h0, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
        chk("total_pulses", pulses, exp_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
